// File: rtl/sprite_linebuf_pkg.sv
// Shared constants and state type for the double-banked sprite line buffer.
package sprite_linebuf_pkg;
  localparam logic [8:0] HLAST    = 9'd383;
  localparam logic [8:0] VLAST    = 9'd262;
  localparam int         LINE_LEN = 256;
  localparam logic [3:0] TRANSP   = 4'h0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/linebuf_ram.sv
// One line bank: single write port, single read port with registered,
// enable-gated read data that holds between reads.
module linebuf_ram
  import sprite_linebuf_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [7:0]       i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic             i_re,
  input  logic [7:0]       i_raddr,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] r_mem [LINE_LEN];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sprite_linebuf.sv
// Ping-pong sprite line buffer: renderer fills one bank while the other is
// displayed and erased behind the beam; banks swap at the end of each line.
module sprite_linebuf
  import sprite_linebuf_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [8:0]       hcount,
  input  logic [8:0]       vcount,
  input  logic             hb,
  input  logic             wr_en,
  input  logic [7:0]       wr_x,
  input  logic [PIX_W-1:0] wr_pix,
  output logic             wr_ready,
  output logic             line_start,
  output logic [8:0]       render_line,
  output logic [PIX_W-1:0] pix_out
);

  state_e           r_state, w_state_nxt;
  logic [7:0]       r_clr_addr;
  logic             r_bank_sel;
  logic             r_line_start;
  logic [8:0]       r_render_line;
  logic             r_rd_vld_p1;
  logic             r_pix_vld_p1;
  logic             r_rd_bank_p1;
  logic [7:0]       r_rd_addr_p1;

  logic             w_clear, w_swap, w_rd, w_wr_keep;
  logic             w_we    [2];
  logic             w_re    [2];
  logic [7:0]       w_waddr [2];
  logic [PIX_W-1:0] w_wdata [2];
  logic [PIX_W-1:0] w_rdata [2];

  assign w_clear   = (r_state == ST_CLEAR);
  assign w_swap    = (r_state == ST_RUN) && ce_pix && (hcount == HLAST);
  assign w_rd      = (r_state == ST_RUN) && ce_pix && !hb;
  assign wr_ready  = (r_state == ST_RUN) && !w_swap;
  assign w_wr_keep = wr_en && wr_ready && (wr_pix[3:0] != TRANSP);

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_addr == 8'hFF) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clr_addr    <= '0;
      r_bank_sel    <= 1'b0;
      r_line_start  <= 1'b0;
      r_render_line <= '0;
      r_rd_vld_p1   <= 1'b0;
      r_pix_vld_p1  <= 1'b0;
    end else begin
      r_clr_addr   <= w_clear ? r_clr_addr + 8'd1 : '0;
      r_line_start <= w_swap;
      if (w_swap) begin
        r_bank_sel    <= ~r_bank_sel;
        r_render_line <= (vcount == VLAST) ? '0 : vcount + 9'd1;
      end
      r_rd_vld_p1 <= w_rd;
      if (w_clear)     r_pix_vld_p1 <= 1'b0;
      else if (ce_pix) r_pix_vld_p1 <= !hb;
    end
  end

  // p0 -> p1: remember which bank/address was read so it can be erased next cycle
  always_ff @(posedge clk_sys) begin
    if (w_rd) begin
      r_rd_addr_p1 <= hcount[7:0];
      r_rd_bank_p1 <= r_bank_sel;
    end
  end

  // Per-bank write port: CLEAR sweep, then erase-behind-read, then renderer writes
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_we[b]    = 1'b0;
      w_waddr[b] = wr_x;
      w_wdata[b] = wr_pix;
      w_re[b]    = w_rd && (r_bank_sel == b[0]);
      if (w_clear) begin
        w_we[b]    = 1'b1;
        w_waddr[b] = r_clr_addr;
        w_wdata[b] = '0;
      end else if (r_rd_vld_p1 && (r_rd_bank_p1 == b[0])) begin
        w_we[b]    = 1'b1;
        w_waddr[b] = r_rd_addr_p1;
        w_wdata[b] = '0;
      end else if (w_wr_keep && (r_bank_sel != b[0])) begin
        w_we[b] = 1'b1;
      end
    end
  end

  linebuf_ram #(.PIX_W(PIX_W)) u_ram0 (
    .clk     (clk_sys),
    .i_we    (w_we[0]),
    .i_waddr (w_waddr[0]),
    .i_wdata (w_wdata[0]),
    .i_re    (w_re[0]),
    .i_raddr (hcount[7:0]),
    .o_rdata (w_rdata[0])
  );

  linebuf_ram #(.PIX_W(PIX_W)) u_ram1 (
    .clk     (clk_sys),
    .i_we    (w_we[1]),
    .i_waddr (w_waddr[1]),
    .i_wdata (w_wdata[1]),
    .i_re    (w_re[1]),
    .i_raddr (hcount[7:0]),
    .o_rdata (w_rdata[1])
  );

  assign line_start  = r_line_start;
  assign render_line = r_render_line;
  assign pix_out     = r_pix_vld_p1 ? (r_rd_bank_p1 ? w_rdata[1] : w_rdata[0]) : '0;

endmodule

// File: tb/tb_sprite_linebuf.sv
// Randomised bench for sprite_linebuf: a line-level reference model predicts
// every output each cycle; a separate monitor compares against the DUT.
module tb_sprite_linebuf;

  localparam int PIX_W = 8;

  logic             clk_sys = 1'b0;
  logic             reset;
  logic             ce_pix;
  logic [8:0]       hcount;
  logic [8:0]       vcount;
  logic             hb;
  logic             wr_en;
  logic [7:0]       wr_x;
  logic [PIX_W-1:0] wr_pix;
  logic             wr_ready;
  logic             line_start;
  logic [8:0]       render_line;
  logic [PIX_W-1:0] pix_out;

  always #5 clk_sys = ~clk_sys;

  sprite_linebuf #(.PIX_W(PIX_W)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ce_pix      (ce_pix),
    .hcount      (hcount),
    .vcount      (vcount),
    .hb          (hb),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_pix      (wr_pix),
    .wr_ready    (wr_ready),
    .line_start  (line_start),
    .render_line (render_line),
    .pix_out     (pix_out)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic       ls;
    logic [8:0] rl;
    logic       rdy;
  } exp_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] p;
  } wr_t;

  exp_t exp_q[$];
  wr_t  dir_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the renderer has built for the next line, and what
  // is on screen for the current line.
  logic [7:0] build [256];
  logic [7:0] disp  [256];
  bit         m_run;
  int         m_clr;
  logic [7:0] m_pix;
  logic       m_ls;
  logic [8:0] m_rl;

  int h_cnt, v_cnt;
  bit w_hold;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_clr = 256;
    m_pix = '0;
    m_ls  = 1'b0;
    m_rl  = '0;
    for (int i = 0; i < 256; i++) begin
      build[i] = '0;
      disp[i]  = '0;
    end
  endtask

  // One clock of stimulus: choose inputs, queue the expected outputs,
  // then advance the model across the coming edge.
  task automatic step(input logic rst_i, input bit rnd_wr);
    logic c, h_b, rdy, swp;
    @(posedge clk_sys);
    #2;
    c   = ($urandom_range(0, 3) != 0);
    h_b = (h_cnt >= 256);
    swp = m_run && c && (h_cnt == 383);
    if (!w_hold) begin
      wr_en = 1'b0;
      if (dir_q.size() > 0 && m_run) begin
        wr_t d;
        d      = dir_q.pop_front();
        wr_en  = 1'b1;
        wr_x   = d.x;
        wr_pix = d.p;
      end else if (rnd_wr && (swp || $urandom_range(0, 4) == 0)) begin
        wr_en  = 1'b1;
        wr_x   = 8'($urandom_range(0, 255));
        wr_pix = 8'($urandom);
        if ($urandom_range(0, 3) == 0) wr_pix[3:0] = 4'h0;
      end
    end
    rdy = m_run && !swp;
    exp_q.push_back('{pix: m_pix, ls: m_ls, rl: m_rl, rdy: rdy});

    reset  = rst_i;
    ce_pix = c;
    hcount = 9'(h_cnt);
    vcount = 9'(v_cnt);
    hb     = h_b;

    if (rst_i) begin
      model_reset();
    end else if (!m_run) begin
      m_pix = '0;
      m_ls  = 1'b0;
      m_clr--;
      if (m_clr == 0) m_run = 1'b1;
    end else begin
      if (c) m_pix = h_b ? 8'h00 : disp[h_cnt];
      m_ls = swp;
      if (swp) begin
        m_rl = (v_cnt == 262) ? 9'd0 : 9'(v_cnt + 1);
        disp = build;
        for (int i = 0; i < 256; i++) build[i] = '0;
      end else if (wr_en && wr_pix[3:0] != 4'h0) begin
        build[wr_x] = wr_pix;
      end
    end

    w_hold = wr_en && !rdy;
    if (c) begin
      if (h_cnt == 383) begin
        h_cnt = 0;
        v_cnt = (v_cnt == 262) ? 0 : v_cnt + 1;
      end else begin
        h_cnt++;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pix_out",     16'(pix_out),     16'(e.pix));
        chk("line_start",  16'(line_start),  16'(e.ls));
        chk("render_line", 16'(render_line), 16'(e.rl));
        chk("wr_ready",    16'(wr_ready),    16'(e.rdy));
      end
    end
  end

  initial begin : driver
    int  guard;
    bit  dir_pushed;
    reset  = 1'b1;
    ce_pix = 1'b0;
    hcount = '0;
    vcount = '0;
    hb     = 1'b0;
    wr_en  = 1'b0;
    wr_x   = '0;
    wr_pix = '0;
    h_cnt  = 0;
    v_cnt  = 8;
    w_hold = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("bank_sel_reset", 16'(dut.r_bank_sel), 16'h0);

    // Directed lines: clean banks, single write, transparency, overwrite, erase-behind
    dir_pushed = 1'b0;
    guard = 0;
    while (!(v_cnt == 14 && h_cnt == 0) && guard < 20000) begin
      if (v_cnt == 10 && h_cnt == 0 && !dir_pushed) begin
        dir_q.push_back('{x: 8'd40,  p: 8'h35});
        dir_q.push_back('{x: 8'd100, p: 8'h27});
        dir_q.push_back('{x: 8'd100, p: 8'h30});
        dir_q.push_back('{x: 8'd100, p: 8'h4A});
        dir_q.push_back('{x: 8'd101, p: 8'h30});
        dir_pushed = 1'b1;
      end
      step(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 20000) chk("timeout_phase1", 16'(guard), 16'h0);

    // Random writes, including one forced across every swap, then reset mid-line
    guard = 0;
    while (!(v_cnt == 20 && h_cnt == 120) && guard < 20000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 20000) chk("timeout_phase2", 16'(guard), 16'h0);
    step(1'b1, 1'b1);
    @(negedge clk_sys);
    chk("bank_sel_midline_reset", 16'(dut.r_bank_sel), 16'h0);
    guard = 0;
    while (!(v_cnt == 23 && h_cnt == 0) && guard < 20000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 20000) chk("timeout_phase3", 16'(guard), 16'h0);

    // Frame wrap: vcount 262 -> render_line 0
    v_cnt = 258;
    guard = 0;
    while (!(v_cnt == 3 && h_cnt == 0) && guard < 30000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    if (guard >= 30000) chk("timeout_phase4", 16'(guard), 16'h0);

    repeat (3) @(negedge clk_sys);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
